// File: rtl/lsd_pkg.sv
// -----------------------------------------------------------------------------
// lsd_pkg
// Shared definitions for the LSD segment streamer:
//   - lsd_log2       : ceiling log2 used to size coordinate/address fields
//   - lsd_max        : integer maximum, used for the squared-length width
//   - lsd_state_t    : streamer FSM state encoding
//   - lsd_off_*      : bit offsets of the fields inside a stored segment word,
//                      laid out MSB->LSB as {start_v, start_h, end_v, end_h}
// No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package lsd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOCK  = 3'd1,
      ST_FETCH = 3'd2,
      ST_SEND  = 3'd3,
      ST_DONE  = 3'd4
   } lsd_state_t;

   // Smallest n with 2**n >= value (bounded loop so it stays a constant function).
   function automatic int lsd_log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic int lsd_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // end_h occupies the least significant bits of the word.
   function automatic int lsd_off_end_h();
      return 0;
   endfunction

   function automatic int lsd_off_end_v(input int h_bitw);
      return h_bitw;
   endfunction

   function automatic int lsd_off_start_h(input int h_bitw, input int v_bitw);
      return h_bitw + v_bitw;
   endfunction

   function automatic int lsd_off_start_v(input int h_bitw, input int v_bitw);
      return 2 * h_bitw + v_bitw;
   endfunction

endpackage

// File: rtl/lsd_seg_len2.sv
// -----------------------------------------------------------------------------
// lsd_seg_len2
// Purely combinational squared length of a line segment:
//   len2 = |end_v - start_v|^2 + |end_h - start_h|^2
// L_BITW must be at least 2*max(H_BITW,V_BITW)+1 so the sum cannot overflow.
// Ports:
//   start_v, end_v  in   V_BITW  vertical endpoints
//   start_h, end_h  in   H_BITW  horizontal endpoints
//   len2            out  L_BITW  squared length
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module lsd_seg_len2 #(
   parameter int V_BITW = 9,
   parameter int H_BITW = 10,
   parameter int L_BITW = 21
) (
   input  logic [V_BITW-1:0] start_v,
   input  logic [H_BITW-1:0] start_h,
   input  logic [V_BITW-1:0] end_v,
   input  logic [H_BITW-1:0] end_h,
   output logic [L_BITW-1:0] len2
);

   logic [V_BITW-1:0] diff_v;
   logic [H_BITW-1:0] diff_h;
   logic [L_BITW-1:0] sq_v;
   logic [L_BITW-1:0] sq_h;

   always_comb begin
      // Subtract the smaller from the larger so the difference stays unsigned.
      diff_v = (end_v >= start_v) ? (end_v - start_v) : (start_v - end_v);
      diff_h = (end_h >= start_h) ? (end_h - start_h) : (start_h - end_h);
      sq_v   = L_BITW'(diff_v) * L_BITW'(diff_v);
      sq_h   = L_BITW'(diff_h) * L_BITW'(diff_h);
      len2   = sq_v + sq_h;
   end

endmodule

// File: rtl/lsd_segment_streamer.sv
// -----------------------------------------------------------------------------
// lsd_segment_streamer
// Drains a frozen segment buffer as a valid/accept stream, one segment every
// two cycles (FETCH registers the word and its squared length, SEND offers it).
// Optional feature macro: LSD_STREAM_FILTER_EN -- when defined, segments with
// len2 < MIN_LEN2 are skipped in FETCH and never emitted; out_count then counts
// emitted segments only.
// Ports:
//   clock, n_rst        clock and synchronous active-low reset
//   in_start            one-cycle drain request (honoured only in IDLE)
//   in_buf_ready        buffer frozen and valid
//   in_line_num         number of stored segments (sampled once in LOCK)
//   in_data             word at out_rd_addr, {start_v,start_h,end_v,end_h}
//   out_write_protect   asks the producer to freeze the buffer
//   out_rd_addr         buffer read address
//   out_valid/in_accept stream handshake
//   out_start_v/h, out_end_v/h, out_len2   registered segment and length
//   out_last            current offered segment is the buffer's final one
//   out_done            one-cycle end-of-drain pulse
//   out_count           segments emitted by the most recent drain
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module lsd_segment_streamer
   import lsd_pkg::*;
#(
   parameter  int FRAME_HEIGHT = 480,
   parameter  int FRAME_WIDTH  = 640,
   parameter  int RAM_SIZE     = 4096,
   parameter  int MIN_LEN2     = 100,
   localparam int V_BITW       = lsd_log2(FRAME_HEIGHT),
   localparam int H_BITW       = lsd_log2(FRAME_WIDTH),
   localparam int ADDR_BITW    = lsd_log2(RAM_SIZE),
   localparam int WORD_SIZE    = 2 * (H_BITW + V_BITW),
   localparam int L_BITW       = 2 * lsd_max(H_BITW, V_BITW) + 1
) (
   input  logic                 clock,
   input  logic                 n_rst,
   input  logic                 in_start,
   input  logic                 in_buf_ready,
   input  logic [ADDR_BITW:0]   in_line_num,
   input  logic [WORD_SIZE-1:0] in_data,
   output logic                 out_write_protect,
   output logic [ADDR_BITW-1:0] out_rd_addr,
   output logic                 out_valid,
   input  logic                 in_accept,
   output logic [V_BITW-1:0]    out_start_v,
   output logic [H_BITW-1:0]    out_start_h,
   output logic [V_BITW-1:0]    out_end_v,
   output logic [H_BITW-1:0]    out_end_h,
   output logic [L_BITW-1:0]    out_len2,
   output logic                 out_last,
   output logic                 out_done,
   output logic [ADDR_BITW:0]   out_count
);

   // Index is one bit wider than the address so a full buffer (RAM_SIZE
   // entries) terminates cleanly instead of wrapping.
   localparam int                IDX_W       = ADDR_BITW + 1;
   localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
   localparam logic [L_BITW-1:0] MIN_LEN2_W  = L_BITW'(MIN_LEN2);
   localparam int                OFF_START_V = lsd_off_start_v(H_BITW, V_BITW);
   localparam int                OFF_START_H = lsd_off_start_h(H_BITW, V_BITW);
   localparam int                OFF_END_V   = lsd_off_end_v(H_BITW);
   localparam int                OFF_END_H   = lsd_off_end_h();

`ifdef LSD_STREAM_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   lsd_state_t         state_reg, state_next;
   logic [IDX_W-1:0]   index_reg, index_next;
   logic [IDX_W-1:0]   line_num_reg, line_num_next;
   logic [IDX_W-1:0]   count_reg, count_next;
   logic [V_BITW-1:0]  start_v_reg, end_v_reg;
   logic [H_BITW-1:0]  start_h_reg, end_h_reg;
   logic [L_BITW-1:0]  len2_reg;
   logic               load_seg;

   logic [V_BITW-1:0]  fetch_start_v, fetch_end_v;
   logic [H_BITW-1:0]  fetch_start_h, fetch_end_h;
   logic [L_BITW-1:0]  fetch_len2;
   logic [IDX_W-1:0]   index_inc;
   logic               index_is_final;
   logic               skip_seg;

   assign fetch_start_v = in_data[OFF_START_V +: V_BITW];
   assign fetch_start_h = in_data[OFF_START_H +: H_BITW];
   assign fetch_end_v   = in_data[OFF_END_V   +: V_BITW];
   assign fetch_end_h   = in_data[OFF_END_H   +: H_BITW];

   lsd_seg_len2 #(
      .V_BITW (V_BITW),
      .H_BITW (H_BITW),
      .L_BITW (L_BITW)
   ) u_len2 (
      .start_v (fetch_start_v),
      .start_h (fetch_start_h),
      .end_v   (fetch_end_v),
      .end_h   (fetch_end_h),
      .len2    (fetch_len2)
   );

   // index+1 == line_num is the same test as index == line_num-1 but never
   // underflows.
   assign index_inc      = index_reg + IDX_ONE;
   assign index_is_final = (index_inc == line_num_reg);
   assign skip_seg       = FILTER_EN && (fetch_len2 < MIN_LEN2_W);

   always_comb begin
      state_next    = state_reg;
      index_next    = index_reg;
      line_num_next = line_num_reg;
      count_next    = count_reg;
      load_seg      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (in_start) begin
               state_next = ST_LOCK;
               count_next = '0;
            end
         end
         ST_LOCK: begin
            if (in_buf_ready) begin
               index_next    = '0;
               line_num_next = in_line_num;
               state_next    = (in_line_num == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (skip_seg) begin
               index_next = index_inc;
               state_next = index_is_final ? ST_DONE : ST_FETCH;
            end else begin
               load_seg   = 1'b1;
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (in_accept) begin
               index_next = index_inc;
               count_next = count_reg + IDX_ONE;
               state_next = index_is_final ? ST_DONE : ST_FETCH;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!n_rst) begin
         state_reg    <= ST_IDLE;
         index_reg    <= '0;
         line_num_reg <= '0;
         count_reg    <= '0;
         start_v_reg  <= '0;
         start_h_reg  <= '0;
         end_v_reg    <= '0;
         end_h_reg    <= '0;
         len2_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         index_reg    <= index_next;
         line_num_reg <= line_num_next;
         count_reg    <= count_next;
         if (load_seg) begin
            start_v_reg <= fetch_start_v;
            start_h_reg <= fetch_start_h;
            end_v_reg   <= fetch_end_v;
            end_h_reg   <= fetch_end_h;
            len2_reg    <= fetch_len2;
         end
      end
   end

   // Protection covers every state in which the buffer is being read; it
   // drops in DONE together with the completion pulse.
   assign out_write_protect = (state_reg == ST_LOCK) || (state_reg == ST_FETCH) ||
                              (state_reg == ST_SEND);
   assign out_valid   = (state_reg == ST_SEND);
   assign out_last    = (state_reg == ST_SEND) && index_is_final;
   assign out_done    = (state_reg == ST_DONE);
   assign out_count   = count_reg;
   assign out_rd_addr = index_reg[ADDR_BITW-1:0];
   assign out_start_v = start_v_reg;
   assign out_start_h = start_h_reg;
   assign out_end_v   = end_v_reg;
   assign out_end_h   = end_h_reg;
   assign out_len2    = len2_reg;

endmodule

// File: tb/tb_lsd_segment_streamer.sv
// -----------------------------------------------------------------------------
// tb_lsd_segment_streamer
// Self-checking bench for lsd_segment_streamer with default parameters
// (480x640 frame, 4096-entry buffer, MIN_LEN2=100). A reference list of the
// segments a drain must emit is built from the stored coordinates; a negedge
// monitor compares every offered segment against it. Literal expectations pin
// the squared-length values and counts. LSD_STREAM_FILTER_EN selects the
// filtered expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lsd_segment_streamer;

   localparam int RS = 4096;
   localparam int ML = 100;
   localparam int VB = 9;
   localparam int HB = 10;
   localparam int AB = 12;
   localparam int WS = 38;
   localparam int LB = 21;

`ifdef LSD_STREAM_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          n_rst = 1'b0;
   logic          in_start = 1'b0;
   logic          in_buf_ready = 1'b0;
   logic [AB:0]   in_line_num = '0;
   logic [WS-1:0] in_data;
   logic          out_write_protect;
   logic [AB-1:0] out_rd_addr;
   logic          out_valid;
   logic          in_accept = 1'b1;
   logic [VB-1:0] out_start_v, out_end_v;
   logic [HB-1:0] out_start_h, out_end_h;
   logic [LB-1:0] out_len2;
   logic          out_last;
   logic          out_done;
   logic [AB:0]   out_count;

   lsd_segment_streamer dut (
      .clock             (clock),
      .n_rst             (n_rst),
      .in_start          (in_start),
      .in_buf_ready      (in_buf_ready),
      .in_line_num       (in_line_num),
      .in_data           (in_data),
      .out_write_protect (out_write_protect),
      .out_rd_addr       (out_rd_addr),
      .out_valid         (out_valid),
      .in_accept         (in_accept),
      .out_start_v       (out_start_v),
      .out_start_h       (out_start_h),
      .out_end_v         (out_end_v),
      .out_end_h         (out_end_h),
      .out_len2          (out_len2),
      .out_last          (out_last),
      .out_done          (out_done),
      .out_count         (out_count)
   );

   always #5 clock = ~clock;

   // Segment buffer: packed words for the DUT, plain coordinates for the model.
   logic [WS-1:0] mem [0:RS-1];
   int fsv [0:RS-1];
   int fsh [0:RS-1];
   int fev [0:RS-1];
   int feh [0:RS-1];
   assign in_data = mem[out_rd_addr];

   typedef struct {
      int sv;
      int sh;
      int ev;
      int eh;
      int len2;
      int idx;
   } seg_t;

   seg_t exp_q[$];
   seg_t e;
   int   obs_len2[$];
   int   lit_q[$];
   int   exp_total = 0;
   int   line_num_model = 0;
   int   done_seen = 0;
   int   emitted = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   bit   verbose = 1'b1;

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic int model_len2(input int sv, input int sh, input int ev, input int eh);
      int dv;
      int dh;
      dv = (ev > sv) ? ev - sv : sv - ev;
      dh = (eh > sh) ? eh - sh : sh - eh;
      return dv * dv + dh * dh;
   endfunction

   task automatic set_seg(input int i, input int sv, input int sh, input int ev, input int eh);
      logic [VB-1:0] a;
      logic [HB-1:0] b;
      logic [VB-1:0] c;
      logic [HB-1:0] d;
      a = VB'(sv);
      b = HB'(sh);
      c = VB'(ev);
      d = HB'(eh);
      mem[i] = {a, b, c, d};
      fsv[i] = sv;
      fsh[i] = sh;
      fev[i] = ev;
      feh[i] = eh;
   endtask

   // Expected emission list for a drain of n stored segments.
   task automatic build_model(input int n);
      seg_t s;
      exp_q.delete();
      obs_len2.delete();
      for (int i = 0; i < n; i++) begin
         s.sv   = fsv[i];
         s.sh   = fsh[i];
         s.ev   = fev[i];
         s.eh   = feh[i];
         s.len2 = model_len2(fsv[i], fsh[i], fev[i], feh[i]);
         s.idx  = i;
         if (!(FILT && s.len2 < ML)) begin
            exp_q.push_back(s);
         end
      end
      exp_total      = exp_q.size();
      line_num_model = n;
      done_seen      = 0;
      emitted        = 0;
      verbose        = (n <= 16);
   endtask

   always @(negedge clock) begin
      if (mon_en && n_rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", out_valid, 0);
            end else begin
               e = exp_q[0];
               check("start_v", out_start_v, e.sv);
               check("start_h", out_start_h, e.sh);
               check("end_v", out_end_v, e.ev);
               check("end_h", out_end_h, e.eh);
               check("len2", out_len2, e.len2);
               check("last", out_last, (e.idx == line_num_model - 1) ? 1 : 0);
               check("rd_addr", out_rd_addr, e.idx % RS);
               check("wp_busy", out_write_protect, 1);
               if (in_accept) begin
                  if (verbose) begin
                     $display("xfer idx=%0d sv=%0d sh=%0d ev=%0d eh=%0d len2=%0d last=%0d",
                              e.idx, out_start_v, out_start_h, out_end_v, out_end_h,
                              out_len2, out_last);
                  end
                  obs_len2.push_back(int'(out_len2));
                  void'(exp_q.pop_front());
                  emitted++;
               end
            end
         end
         if (out_done) begin
            check("done_queue_left", exp_q.size(), 0);
            check("done_count", out_count, exp_total);
            check("done_wp", out_write_protect, 0);
            check("done_valid", out_valid, 0);
            done_seen++;
            $display("drain n=%0d emitted=%0d count=%0d", line_num_model, emitted, out_count);
         end
      end
   end

   task automatic start_drain(input int n);
      in_start     = 1'b1;
      in_line_num  = (AB + 1)'(n);
      in_buf_ready = 1'b0;
      @(posedge clock); #1;
      in_start = 1'b0;
      check("wp_after_start", out_write_protect, 1);
      check("no_valid_in_lock", out_valid, 0);
      @(posedge clock); #1;
      in_buf_ready = 1'b1;
   endtask

   // Full drain; optional accept stall on the first segment and a stray
   // in_start pulse while busy. After the first offered segment the buffer
   // ready flag and line count are disturbed, which must have no effect.
   task automatic drain(input int n, input int stall, input bit poke);
      int  budget;
      int  stall_left;
      bit  seen_valid;
      build_model(n);
      in_accept  = 1'b1;
      stall_left = stall;
      seen_valid = 1'b0;
      start_drain(n);
      budget = 2 * n + stall + 20;
      for (int c = 0; c < budget && done_seen == 0; c++) begin
         @(posedge clock); #1;
         if (out_valid && !seen_valid) begin
            seen_valid   = 1'b1;
            in_buf_ready = 1'b0;
            in_line_num  = in_line_num + (AB + 1)'(7);
            in_start     = poke;
         end else begin
            in_start = 1'b0;
         end
         if (out_valid && stall_left > 0) begin
            in_accept = 1'b0;
            stall_left--;
         end else begin
            in_accept = 1'b1;
         end
      end
      in_start = 1'b0;
      check("done_seen", done_seen, 1);
      repeat (3) @(posedge clock);
      #1;
      check("done_single_pulse", done_seen, 1);
      check("idle_wp", out_write_protect, 0);
      check("idle_valid", out_valid, 0);
      check("count_hold", out_count, exp_total);
      in_accept = 1'b1;
   endtask

   task automatic check_lits(input string name);
      check({name, "_n"}, obs_len2.size(), lit_q.size());
      for (int i = 0; i < lit_q.size() && i < obs_len2.size(); i++) begin
         check(name, obs_len2[i], lit_q[i]);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_wp"}, out_write_protect, 0);
      check({name, "_valid"}, out_valid, 0);
      check({name, "_last"}, out_last, 0);
      check({name, "_done"}, out_done, 0);
      check({name, "_count"}, out_count, 0);
      check({name, "_rd_addr"}, out_rd_addr, 0);
      check({name, "_start_v"}, out_start_v, 0);
      check({name, "_start_h"}, out_start_h, 0);
      check({name, "_end_v"}, out_end_v, 0);
      check({name, "_end_h"}, out_end_h, 0);
      check({name, "_len2"}, out_len2, 0);
   endtask

   initial begin
      int hit;
      int exp_cnt;

      for (int i = 0; i < RS; i++) begin
         set_seg(i, $urandom_range(0, 479), $urandom_range(0, 639),
                    $urandom_range(0, 479), $urandom_range(0, 639));
      end

      // Reset state
      n_rst = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      n_rst  = 1'b1;
      mon_en = 1'b1;
      @(posedge clock); #1;

      // Three segments, accept tied high: lengths 109, 16900, 408321
      set_seg(0, 10, 20, 13, 30);
      set_seg(1, 100, 200, 50, 80);
      set_seg(2, 0, 0, 0, 639);
      drain(3, 0, 1'b0);
      check("three_count", out_count, 3);
      lit_q = {109, 16900, 408321};
      check_lits("three_len2");

      // Empty buffer
      drain(0, 0, 1'b0);
      check("empty_count", out_count, 0);

      // Accept held low for 5 cycles on the first segment, stray in_start
      set_seg(0, 200, 300, 190, 310);
      set_seg(1, 5, 5, 25, 5);
      drain(2, 5, 1'b1);
      check("stall_count", out_count, 2);
      lit_q = {200, 400};
      check_lits("stall_len2");

      // Squared-length corner cases
      set_seg(0, 0, 0, 3, 4);
      set_seg(1, 0, 0, 479, 639);
      drain(2, 0, 1'b0);
`ifdef LSD_STREAM_FILTER_EN
      lit_q = {637762};
`else
      lit_q = {25, 637762};
`endif
      check_lits("corner_len2");

      // Filter vectors: lengths 25, 169, 64
      set_seg(0, 0, 0, 3, 4);
      set_seg(1, 0, 0, 5, 12);
      set_seg(2, 0, 0, 8, 0);
      drain(3, 0, 1'b0);
`ifdef LSD_STREAM_FILTER_EN
      exp_cnt = 1;
      lit_q   = {169};
`else
      exp_cnt = 3;
      lit_q   = {25, 169, 64};
`endif
      check("filter_count", out_count, exp_cnt);
      check_lits("filter_len2");

      // Reset while the second of four segments is offered
      set_seg(0, 10, 10, 30, 30);
      set_seg(1, 40, 40, 60, 70);
      set_seg(2, 100, 0, 120, 0);
      set_seg(3, 300, 600, 0, 0);
      build_model(4);
      start_drain(4);
      hit = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clock); #1;
         if (out_valid && emitted == 1) begin
            hit = 1;
            break;
         end
      end
      check("reach_second_seg", hit, 1);
      mon_en    = 1'b0;
      n_rst     = 1'b0;
      in_accept = 1'b0;
      @(posedge clock); #1;
      check_all_zero("mid_reset");
      n_rst        = 1'b1;
      in_buf_ready = 1'b0;
      in_accept    = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         check("no_done_after_reset", out_done, 0);
         check("idle_after_reset", out_write_protect, 0);
      end
      mon_en = 1'b1;
      drain(4, 0, 1'b0);
      check("redrain_first_len2", (obs_len2.size() > 0) ? obs_len2[0] : -1, 800);

      // Full buffer: addresses 0..RAM_SIZE-1 without wrap
      for (int i = 0; i < 8; i++) begin
         set_seg(i, $urandom_range(0, 479), $urandom_range(0, 639),
                    $urandom_range(0, 479), $urandom_range(0, 639));
      end
      drain(RS, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
